// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule slice: sizes, index/state types, S-box.
package aes_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned NUM_ROUNDS = 10;

  typedef logic [3:0] rk_idx_t;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 in GF(2^8), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = x;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// Combinational single-round AES-128 key expansion: wOut = round key roundNum from wIn.
module key_expansion
  import aes_pkg::*;
(
  input  logic [0:127] wIn,
  input  logic [3:0]   roundNum,
  output logic [0:127] wOut
);

  logic [7:0]  w_rcon;
  logic [0:31] w_temp;
  logic [0:31] w_n0;
  logic [0:31] w_n1;
  logic [0:31] w_n2;
  logic [0:31] w_n3;

  always_comb begin
    w_rcon = 8'h00;
    case (roundNum)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // SubWord(RotWord(w3)) ^ Rcon
  assign w_temp = {sbox(wIn[104:111]), sbox(wIn[112:119]), sbox(wIn[120:127]),
                   sbox(wIn[96:103])} ^ {w_rcon, 24'h000000};

  assign w_n0 = wIn[0:31]   ^ w_temp;
  assign w_n1 = wIn[32:63]  ^ w_n0;
  assign w_n2 = wIn[64:95]  ^ w_n1;
  assign w_n3 = wIn[96:127] ^ w_n2;
  assign wOut = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key-schedule controller: expands one round per clock into an
// 11-entry round-key store and serves keys through a registered read port.
module key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:KEY_W-1] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [0:KEY_W-1] rd_key,
  output logic             rd_valid
);

  import aes_pkg::*;

  localparam rk_idx_t LastRound = rk_idx_t'(NUM_ROUNDS);

  ks_state_e        r_state;
  rk_idx_t          r_round_cnt;
  logic [0:KEY_W-1] r_cur_key;
  logic [0:KEY_W-1] r_slot [0:10];
  logic             r_busy;
  logic             r_done;
  logic             r_keys_valid;
  logic [0:KEY_W-1] r_rd_key;
  logic             r_rd_valid;

  logic [0:KEY_W-1] w_next;
  logic             w_rd_ok;

  key_expansion u_key_expansion (
    .wIn      (r_cur_key),
    .roundNum (r_round_cnt),
    .wOut     (w_next)
  );

  // A slot is readable only once written for the key currently being expanded or held.
  assign w_rd_ok = (rd_idx <= LastRound) &&
                   ((r_state == READY) || ((r_state == EXPAND) && (rd_idx < r_round_cnt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_round_cnt  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_rd_key     <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_rd_ok) begin
        r_rd_key   <= r_slot[rd_idx];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_key   <= '0;
        r_rd_valid <= 1'b0;
      end

      case (r_state)
        IDLE, READY: begin
          if (start) begin
            r_slot[0]    <= key_in;
            r_cur_key    <= key_in;
            r_round_cnt  <= rk_idx_t'(1);
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= EXPAND;
          end
        end
        EXPAND: begin
          r_slot[r_round_cnt] <= w_next;
          r_cur_key           <= w_next;
          if (r_round_cnt == LastRound) begin
            r_state      <= READY;
            r_round_cnt  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_keys_valid <= 1'b1;
          end else begin
            r_round_cnt <= r_round_cnt + rk_idx_t'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign keys_valid = r_keys_valid;
  assign rd_key     = r_rd_key;
  assign rd_valid   = r_rd_valid;

endmodule
